// File: rtl/bus_split_fifo_pkg.sv
// Shared constants and helpers for the 48+64-bit merged bus.
// The merge side uses the same widths, so both ends agree on the {A, B} layout.
package bus_split_fifo_pkg;

    localparam int unsigned BUS_A_W = 48;
    localparam int unsigned BUS_B_W = 64;
    localparam int unsigned BUS_W   = BUS_A_W + BUS_B_W;

    typedef struct packed {
        logic [BUS_A_W-1:0] a;
        logic [BUS_B_W-1:0] b;
    } bus_fields_t;

    // A sits in the upper bits, B in the lower bits.
    function automatic bus_fields_t split_word(input logic [BUS_W-1:0] word);
        bus_fields_t fields;
        fields.a = word[BUS_W-1:BUS_B_W];
        fields.b = word[BUS_B_W-1:0];
        return fields;
    endfunction

endpackage

// File: rtl/bus_fifo_core.sv
// Generic DEPTH x W FIFO storage with a single push/pop interface.
// The head word is read combinationally; the storage array itself is not reset.
module bus_fifo_core #(
    parameter int unsigned W     = 112,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PW   = $clog2(DEPTH),
    localparam int unsigned CW   = PW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  wdata,
    output logic [W-1:0]  head,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] level
);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign level   = count_q;
    assign head    = mem[rd_ptr_q];

    // Guards keep the pointers consistent even if a caller misbehaves.
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        unique case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/bus_split_fifo.sv
// Buffers merged {A, B} words and forks the head word onto two independent
// valid/ready channels; the word pops once both of its fields have been taken.
module bus_split_fifo
    import bus_split_fifo_pkg::*;
#(
    parameter int unsigned A_W   = BUS_A_W,
    parameter int unsigned B_W   = BUS_B_W,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned LW   = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [A_W+B_W-1:0] in_data,
    output logic             a_valid,
    input  logic             a_ready,
    output logic [A_W-1:0]   a_data,
    output logic             b_valid,
    input  logic             b_ready,
    output logic [B_W-1:0]   b_data,
    output logic [LW-1:0]    level
);

    logic [A_W+B_W-1:0] head;
    logic               full;
    logic               empty;
    logic               push;
    logic               pop;
    logic               a_fire;
    logic               b_fire;
    logic               a_done_q, a_done_d;
    logic               b_done_q, b_done_d;

    bus_fifo_core #(
        .W     (A_W + B_W),
        .DEPTH (DEPTH)
    ) u_core (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .wdata (in_data),
        .head  (head),
        .full  (full),
        .empty (empty),
        .level (level)
    );

    // Ready comes from registered state only: a same-cycle pop never frees a slot.
    assign in_ready = ~full & ~reset;
    assign push     = in_valid & in_ready;

    assign a_valid  = ~empty & ~a_done_q;
    assign b_valid  = ~empty & ~b_done_q;
    assign a_fire   = a_valid & a_ready;
    assign b_fire   = b_valid & b_ready;
    assign pop      = (a_done_q | a_fire) & (b_done_q | b_fire);

    if (A_W == BUS_A_W && B_W == BUS_B_W) begin : g_pkg_split
        bus_fields_t fields;
        assign fields = split_word(head);
        assign a_data = fields.a;
        assign b_data = fields.b;
    end else begin : g_param_split
        assign a_data = head[A_W+B_W-1:B_W];
        assign b_data = head[B_W-1:0];
    end

    always_comb begin
        a_done_d = a_done_q;
        b_done_d = b_done_q;
        if (pop) begin
            a_done_d = 1'b0;
            b_done_d = 1'b0;
        end else begin
            if (a_fire) begin
                a_done_d = 1'b1;
            end
            if (b_fire) begin
                b_done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_done_q <= 1'b0;
            b_done_q <= 1'b0;
        end else begin
            a_done_q <= a_done_d;
            b_done_q <= b_done_d;
        end
    end

endmodule

// File: doc/bus_split_fifo.md
Name: bus_split_fifo

Overview:
- Receive-side counterpart of the 48+64-bit bus merge.
- Accepts merged 112-bit words on a valid/ready stream and buffers them in a small FIFO.
- Splits the head word into an A field (upper 48 bits) and a B field (lower 64 bits).
- Presents A and B on two independent valid/ready output channels. Downstream A and B consumers may drain at different rates.

Parameters:
- A_W, 48: width of the A field, taken from the upper bits of in_data.
- B_W, 64: width of the B field, taken from the lower bits of in_data.
- DEPTH, 4: FIFO depth in merged words. Must be a power of two and at least 2.

Ports:
- clk  in  1  sole clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  merged word present.
- in_ready  out  1  FIFO can accept a word.
- in_data  in  A_W+B_W  merged word, laid out as {A, B}.
- a_valid  out  1  A field of the head word is available.
- a_ready  in  1  A consumer accepts.
- a_data  out  A_W  head word bits [A_W+B_W-1:B_W].
- b_valid  out  1  B field of the head word is available.
- b_ready  in  1  B consumer accepts.
- b_data  out  B_W  head word bits [B_W-1:0].
- level  out  clog2(DEPTH)+1  number of stored words.

Behaviour:
- Interface: one clock, clk. Reset is asynchronous and active-high, on port reset.
- Reset clears wr_ptr, rd_ptr, count, a_done and b_done to 0.
  - Resulting outputs: a_valid=0, b_valid=0, level=0.
  - in_ready is forced to 0 while reset is high. It is 1 in the first cycle after reset deasserts.
  - Storage array is not reset.
  - a_data and b_data are don't-care whenever their valid is low.
- Reset mid-operation discards all stored words and partial-consume flags immediately.
- in_ready = (count != DEPTH). It depends only on registered state. A pop in the same cycle does not open a slot for a push into a full FIFO.
- Push: in_valid & in_ready writes in_data at wr_ptr, then increments wr_ptr modulo DEPTH.
- Outputs:
  - a_valid = (count != 0) & ~a_done.
  - b_valid = (count != 0) & ~b_done.
  - a_data and b_data are read combinationally from mem[rd_ptr].
- Latency: a word pushed into an empty FIFO at edge N makes a_valid and b_valid high after edge N. This gives 1 cycle of latency, with no bypass.
- Fire events: a_fire = a_valid & a_ready; b_fire = b_valid & b_ready.
- Pop condition: (a_done | a_fire) & (b_done | b_fire).
  - On pop: rd_ptr increments modulo DEPTH, and a_done and b_done both clear to 0.
  - With no pop: a_done is set on a_fire, and b_done is set on b_fire.
  - A field already consumed is never re-presented for the same word.
- Count update: +1 on push only; -1 on pop only; unchanged on push and pop together. level = count.
- A and B may fire in the same cycle; this pops in one cycle.
- Holding: data and valid of a pending field stay stable until that field fires.
- Pointer wrap is silent. Overflow and underflow are impossible by construction.
- Assertions for the bench:
  - count <= DEPTH.
  - a_done and b_done are never both 1 at a clock edge.

Decomposition:
- Shared package holds:
  - BUS_A_W = 48, BUS_B_W = 64, BUS_W = BUS_A_W + BUS_B_W. These are the same constants the merge side uses.
  - A helper function that splits a BUS_W word into its A and B fields.
- One natural sub-module: bus_fifo_core.
  - Generic DEPTH x BUS_W storage with pointers and count.
  - Single push/pop interface.
  - Exposes the head word and a full flag.
- The top level adds the fork logic (a_done/b_done flags, pop generation).

Test Plan:
- Reset then idle: reset pulsed during traffic → in_ready=0 while reset is high; a_valid=b_valid=0 and level=0 immediately; in_ready=1 the first cycle after release.
- Single word, both outputs ready: push in_data=112'h123456789ABC_0011223344556677 → one cycle later a_data=48'h123456789ABC and b_data=64'h0011223344556677 with both valids high; both fire together; level returns to 0 the next cycle.
- Skewed consumers: with b_ready=0, push 2 words → A of word0 fires; a_valid drops while b_valid stays 1 and level=2; raise b_ready → word0 pops, word1's A and B present, level=1.
- Fill to full: hold both readies low and push 5 words with DEPTH=4 → in_ready=0 after 4 accepts, level=4, 5th word held by the source; drain all → order preserved, and the 5th word enters only after the first pop.
- Wrap and throughput: both readies high, in_valid high for 20 words with incrementing payload → after the first-cycle latency, one word per cycle; outputs in order across multiple pointer wraps; level stays at 1.
- Random backpressure: 1000 words with randomized a_ready, b_ready and in_valid → every A and B field is received exactly once, in order; scoreboard matches; assertions never fire.
